hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/riscv_pipe_pkg.sv | 38 +++
 rtl/hazard_unit_sat_counter.sv | 30 +++
 rtl/hazard_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared encodings for the pipeline hazard logic: hazard FSM
//               states, forward-select codes and the load result source.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_REDIR   = 2'd2
    } hzState_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    // Operand source for one Execute-stage register; Memory beats Writeback, x0 never forwards
    function automatic logic [1:0] fwdSel(
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW,
        input logic [4:0] rsE
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rsE))
            return FWD_M;
        else if (regWriteW && (rdW != 5'd0) && (rdW == rsE))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : 16-bit saturating event counter with synchronous
//               active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter (
    input  logic        Clk,
    input  logic        ClrN,
    input  logic        En,
    output logic [15:0] Count
);

    localparam logic [15:0] C_MAX = 16'hFFFF;

    logic [15:0] rCount;

    // Count enabled cycles, holding at the maximum instead of wrapping
    always_ff @(posedge Clk) begin
        if (!ClrN)
            rCount <= 16'd0;
        else if (En && (rCount != C_MAX))
            rCount <= rCount + 16'd1;
    end

    assign Count = rCount;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Five-stage pipeline hazard control: operand forwarding,
//               load-use stall, branch/jalr redirect flushes and
//               stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import riscv_pipe_pkg::*;
(
    input  logic        Clk,
    input  logic        RstN,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResSrcE,
    input  logic        PCSrcE,
    input  logic        RegWriteM,
    input  logic        JalrM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    hzState_t rState;
    hzState_t wNextState;
    logic     wLoadUse;

    assign wLoadUse = (ResSrcE == RES_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Forward selects; forced to the register file while held in reset
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RstN) begin
            ForwardAE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
            ForwardBE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
        end
    end

    // Stall/flush decode and next state; a redirect always outranks a stall
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        wNextState = ST_RUN;
        if (!RstN) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            case (rState)
                ST_RUN, ST_LDSTALL: begin
                    if (JalrM) begin
                        FlushD     = 1'b1;
                        FlushE     = 1'b1;
                        wNextState = ST_REDIR;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (wLoadUse && (rState == ST_RUN)) begin
                        // Only one bubble per load: LDSTALL never re-stalls
                        StallF     = 1'b1;
                        StallD     = 1'b1;
                        FlushE     = 1'b1;
                        wNextState = ST_LDSTALL;
                    end
                end
                ST_REDIR: begin
                    // Second wrong-path slot after a jalr resolved in Memory
                    FlushD = 1'b1;
                    if (JalrM) begin
                        FlushE     = 1'b1;
                        wNextState = ST_REDIR;
                    end
                end
                default: wNextState = ST_RUN;
            endcase
        end
    end

    // Hazard FSM state register
    always_ff @(posedge Clk) begin
        if (!RstN)
            rState <= ST_RUN;
        else
            rState <= wNextState;
    end

    sat_counter uStallCnt (
        .Clk   (Clk),
        .ClrN  (RstN),
        .En    (StallF),
        .Count (StallCnt)
    );

    sat_counter uFlushCnt (
        .Clk   (Clk),
        .ClrN  (RstN),
        .En    (FlushE),
        .Count (FlushCnt)
    );

endmodule
`default_nettype wire
